qam_symbol_packer: RTL
======================

Name: qam_symbol_packer

Overview:
- Upstream feeder for the 16-QAM modulator stage.
- Accepts a byte stream on a valid/ready handshake and splits each byte into two 4-bit QAM symbols.
- Holds each symbol stable for SAMPLES_PER_SYMBOL carrier samples.
- Drives the modulator's symbol input (opQAMBlock) and its valid input (opQAMBlockValid), one update per carrier sample clock.

Parameters:
- SAMPLES_PER_SYMBOL, 8, clock cycles each symbol is held; legal range 1..256.
- MSB_FIRST, 1, 1 = bits [7:4] are emitted first; 0 = bits [3:0] are emitted first.

Ports:
- ipClk  in  1  system/sample clock.
- ipReset  in  1  synchronous reset, active-high.
- ipData  in  8  payload byte.
- ipDataValid  in  1  ipData is valid.
- opDataReady  out  1  block can accept a byte this cycle.
- opQAMBlock  out  4  current symbol to the modulator.
- opQAMBlockValid  out  1  opQAMBlock is valid this cycle.
- opSymbolStrobe  out  1  one-cycle pulse on the first sample of each symbol.
- opBusy  out  1  state is not IDLE, or the pending register is full.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. While ipReset is high at a rising edge of ipClk:
  - all state clears: state = IDLE, sample count = 0, active and pending bytes discarded;
  - opQAMBlock = 0, opQAMBlockValid = 0, opSymbolStrobe = 0, opBusy = 0;
  - opDataReady = 0 while ipReset is high.
- Reset mid-symbol truncates the symbol immediately. No partial symbol is emitted after reset deasserts.
- Storage:
  - active byte register (byte being emitted);
  - one pending byte register with a valid flag.
- Handshake:
  - opDataReady = !pendingValid && !ipReset (combinational).
  - A transfer occurs when ipDataValid && opDataReady at a rising edge.
  - ipData must be held until transfer; the block never drops an accepted byte.
- States:
  - IDLE: valid = 0. On transfer, load the byte into active, go to FIRST.
  - FIRST: emits the first nibble (per MSB_FIRST).
  - SECOND: emits the other nibble.
- Latency: the byte accepted at edge N drives opQAMBlock/opQAMBlockValid from edge N (visible in cycle N+1). Exactly 1 cycle, with opSymbolStrobe = 1 in that cycle.
- Sample counter:
  - width max(1, $clog2(SAMPLES_PER_SYMBOL)); counts 0..SAMPLES_PER_SYMBOL-1 in FIRST and SECOND.
  - On terminal count it wraps to 0 and the nibble changes:
    - FIRST -> SECOND;
    - SECOND -> next byte (see below).
  - opSymbolStrobe = 1 exactly when count = 0 with valid = 1.
- Transfers while a byte is active go to the pending register. Only one byte is buffered beyond the active byte.
- End of SECOND (terminal count), in priority order:
  - pending full: move pending to active, clear pending, go to FIRST, no gap;
  - else a transfer occurs on the same edge: bypass ipData directly into active, go to FIRST, no gap;
  - else go to IDLE; valid = 0 from the next cycle, opQAMBlock holds its last value.
- Simultaneous events: if pending moves to active on the same edge as an input offer, opDataReady was already low, so no transfer occurs. The byte is accepted the next cycle.
- SAMPLES_PER_SYMBOL = 1: each nibble lasts one cycle, so a byte lasts two cycles. Sustained throughput is one byte per 2 cycles with no gaps, as long as the source keeps ipDataValid high.
- opQAMBlock is stable for all SAMPLES_PER_SYMBOL cycles of a symbol.
- opQAMBlockValid is high continuously across back-to-back symbols.

Decomposition:
- Shared package Structures:
  - state enum typedef (IDLE, FIRST, SECOND);
  - QAM symbol width constant = 4;
  - byte width constant = 8.
- No sub-module; the pending register and counter are inline. Implementation target is about 150 RTL lines.

Test Plan:
- Single byte, SAMPLES_PER_SYMBOL=4, MSB_FIRST=1: 0xA5 offered once -> valid for 8 cycles; opQAMBlock=0xA for 4 cycles, then 0x5 for 4; strobe in cycles 1 and 5; then valid=0 and opBusy=0.
- Back-to-back stream, SAMPLES_PER_SYMBOL=2: 0x12, 0x34, 0x56 with ipDataValid held high -> symbols 1,2,3,4,5,6, each 2 cycles; valid never drops; 12 valid cycles total.
- Backpressure, SAMPLES_PER_SYMBOL=4: offer 3 bytes continuously -> ready low after the 2nd transfer until pending drains at cycle 8; all 3 bytes emitted in order; none lost or duplicated.
- Reset mid-symbol: assert ipReset in cycle 3 of symbol 0xC -> the next cycle shows valid=0, opQAMBlock=0, ready=0; after release, 0x7E emits 7 then E cleanly.
- SAMPLES_PER_SYMBOL=1, MSB_FIRST=0: stream 0xAB, 0xCD -> symbols B, A, D, C on consecutive cycles; strobe high every valid cycle.
- Same-edge bypass, SAMPLES_PER_SYMBOL=3: pending empty, present 0x9F exactly on the terminal-count edge of SECOND -> next cycle opQAMBlock=0x9 with no invalid gap.

Source files
------------

// File: rtl/qam_symbol_packer_pkg.sv
`default_nettype none
// ============================================================================
// qam_symbol_packer_pkg : shared types and widths for the 16-QAM byte packer
// Rev 1.0
// ============================================================================
package qam_symbol_packer_pkg;

  localparam int QAM_W  = 4;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/qam_symbol_packer.sv
`default_nettype none
// ============================================================================
// qam_symbol_packer : splits bytes into two 4-bit QAM symbols, each held for
//                     SAMPLES_PER_SYMBOL cycles, with one byte of buffering
// Rev 1.0
// ============================================================================
module qam_symbol_packer
  import qam_symbol_packer_pkg::*;
#(
  parameter int SAMPLES_PER_SYMBOL = 8,
  parameter int MSB_FIRST          = 1
) (
  input  logic              ipClk,
  input  logic              ipReset,
  input  logic [BYTE_W-1:0] ipData,
  input  logic              ipDataValid,
  output logic              opDataReady,
  output logic [QAM_W-1:0]  opQAMBlock,
  output logic              opQAMBlockValid,
  output logic              opSymbolStrobe,
  output logic              opBusy
);

  localparam int              CNT_W    = (SAMPLES_PER_SYMBOL > 1) ? $clog2(SAMPLES_PER_SYMBOL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_SYMBOL - 1);

  function automatic logic [QAM_W-1:0] nibble(input logic [BYTE_W-1:0] b, input logic second);
    logic hi;
    hi = (MSB_FIRST != 0) ^ second;
    return hi ? b[7:4] : b[3:0];
  endfunction

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [BYTE_W-1:0]  active_byte, active_nxt;
  logic [BYTE_W-1:0]  pend_byte, pend_nxt;
  logic               pend_valid, pend_valid_nxt;
  logic [QAM_W-1:0]   symbol, symbol_nxt;
  logic               xfer;
  logic               last_sample;

  assign opDataReady     = !pend_valid && !ipReset;
  assign xfer            = ipDataValid && opDataReady;
  assign last_sample     = (cnt == CNT_LAST);
  assign opQAMBlock      = symbol;
  assign opQAMBlockValid = (state != IDLE);
  assign opSymbolStrobe  = (state != IDLE) && (cnt == '0);
  assign opBusy          = (state != IDLE) || pend_valid;

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      state       <= IDLE;
      cnt         <= '0;
      active_byte <= '0;
      pend_byte   <= '0;
      pend_valid  <= 1'b0;
      symbol      <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      active_byte <= active_nxt;
      pend_byte   <= pend_nxt;
      pend_valid  <= pend_valid_nxt;
      symbol      <= symbol_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    active_nxt     = active_byte;
    pend_nxt       = pend_byte;
    pend_valid_nxt = pend_valid;
    symbol_nxt     = symbol;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          active_nxt = ipData;
          symbol_nxt = nibble(ipData, 1'b0);
          cnt_nxt    = '0;
          state_nxt  = FIRST;
        end
      end
      FIRST: begin
        if (xfer) begin
          pend_nxt       = ipData;
          pend_valid_nxt = 1'b1;
        end
        if (last_sample) begin
          cnt_nxt    = '0;
          symbol_nxt = nibble(active_byte, 1'b1);
          state_nxt  = SECOND;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      SECOND: begin
        if (last_sample) begin
          cnt_nxt = '0;
          // A buffered byte outranks a same-edge offer; ready was low anyway.
          if (pend_valid) begin
            active_nxt     = pend_byte;
            pend_valid_nxt = 1'b0;
            symbol_nxt     = nibble(pend_byte, 1'b0);
            state_nxt      = FIRST;
          end else if (xfer) begin
            active_nxt = ipData;
            symbol_nxt = nibble(ipData, 1'b0);
            state_nxt  = FIRST;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
          if (xfer) begin
            pend_nxt       = ipData;
            pend_valid_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire
